// File: rtl/fp_arb_pkg.sv
// Shared types and default widths for the FPro MMIO bus arbiter.
package fp_arb_pkg;

    localparam int unsigned FP_ADDR_W = 21;
    localparam int unsigned FP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef logic master_id_t;

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational two-way picker: round-robin on contention when rr_en, else m0 priority.
module fp_rr_pick
    import fp_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    input  logic       rr_en,
    output logic       gnt_valid,
    output master_id_t gnt_id
);

    // Contention goes to the master that did not win last; a lone requester always wins.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b11) begin
            gnt_id = rr_en ? ~last_grant : 1'b0;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/fp_bus_arbiter.sv
// Shares one FPro MMIO bus between two req/ack masters, one single-cycle transaction per grant.
module fp_bus_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = FP_ADDR_W,
    parameter int unsigned DATA_W = FP_DATA_W,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,
    output logic              s_mmio_cs,
    output logic              s_mmio_wr,
    output logic              s_mmio_rd,
    output logic [ADDR_W-1:0] s_mmio_addr,
    output logic [DATA_W-1:0] s_mmio_wr_data,
    input  logic [DATA_W-1:0] s_mmio_rd_data,
    output logic              busy,
    output master_id_t        grant_id
);

    arb_state_t        state, state_nxt;
    master_id_t        last_grant, last_nxt, grant_nxt;
    logic              gnt_valid;
    master_id_t        gnt_id;
    logic              cs_nxt, wr_nxt, rd_nxt, busy_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [1:0]        ack_nxt;
    logic [1:0]        rd_cap;

    fp_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .rr_en      (RR_EN),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the registered bus, ack and grant outputs.
    // The bus registers double as the latched request: they hold the winner's fields during ISSUE.
    always_comb begin
        state_nxt = state;
        cs_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        ack_nxt   = 2'b00;
        rd_cap    = 2'b00;
        busy_nxt  = 1'b0;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_nxt = ISSUE;
                    cs_nxt    = 1'b1;
                    wr_nxt    = gnt_id ? m1_wr : m0_wr;
                    rd_nxt    = ~wr_nxt;
                    addr_nxt  = gnt_id ? m1_addr : m0_addr;
                    wdata_nxt = gnt_id ? m1_wr_data : m0_wr_data;
                    grant_nxt = gnt_id;
                    busy_nxt  = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt         = RESP;
                ack_nxt[grant_id] = 1'b1;
                rd_cap[grant_id]  = s_mmio_rd;
                busy_nxt          = 1'b1;
            end
            RESP: begin
                state_nxt = IDLE;
                last_nxt  = grant_id;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered bus strobes, acks, busy and grant bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_mmio_cs      <= 1'b0;
            s_mmio_wr      <= 1'b0;
            s_mmio_rd      <= 1'b0;
            s_mmio_addr    <= '0;
            s_mmio_wr_data <= '0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= 1'b0;
            last_grant     <= 1'b1;
        end else begin
            s_mmio_cs      <= cs_nxt;
            s_mmio_wr      <= wr_nxt;
            s_mmio_rd      <= rd_nxt;
            s_mmio_addr    <= addr_nxt;
            s_mmio_wr_data <= wdata_nxt;
            m0_ack         <= ack_nxt[0];
            m1_ack         <= ack_nxt[1];
            busy           <= busy_nxt;
            grant_id       <= grant_nxt;
            last_grant     <= last_nxt;
        end
    end

    // Read data capture; each master's register changes only on its own completed read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rd_data <= '0;
            m1_rd_data <= '0;
        end else begin
            if (rd_cap[0]) m0_rd_data <= s_mmio_rd_data;
            if (rd_cap[1]) m1_rd_data <= s_mmio_rd_data;
        end
    end

endmodule

// File: tb/tb_fp_bus_arbiter.sv
// Scoreboard bench for fp_bus_arbiter: a round-robin and a fixed-priority instance share master inputs.
module tb_fp_bus_arbiter;
    import fp_arb_pkg::*;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;

    typedef struct packed {
        int unsigned   cyc;
        logic          id;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bus_ev_t;

    typedef struct packed {
        int unsigned   cyc;
        logic          id;
        logic [DW-1:0] rd;
    } ack_ev_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;

    logic [DW-1:0] a_m0_rd_data, a_m1_rd_data, b_m0_rd_data, b_m1_rd_data;
    logic          a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack;
    logic          a_cs, a_wr, a_rd, b_cs, b_wr, b_rd;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_busy, b_busy;
    master_id_t    a_gid, b_gid;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned dirty_cnt = 0;

    bus_ev_t a_bus_q[$], b_bus_q[$], exp_bus_q[$];
    ack_ev_t a_ack_q[$], b_ack_q[$], exp_ack_q[$];

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return (a == 21'h000080) ? 32'h0000_BEEF : {11'h3C5, a};
    endfunction

    function automatic bus_ev_t mk_bus(input int unsigned c, input logic id, input logic wr,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus_ev_t e;
        e.cyc = c; e.id = id; e.wr = wr; e.rd = ~wr; e.addr = addr; e.data = data;
        return e;
    endfunction

    function automatic ack_ev_t mk_ack(input int unsigned c, input logic id, input logic [DW-1:0] rd);
        ack_ev_t e;
        e.cyc = c; e.id = id; e.rd = rd;
        return e;
    endfunction

    // Combinational slave for each instance.
    assign a_rdata = (a_cs && a_rd) ? slave_data(a_addr) : '0;
    assign b_rdata = (b_cs && b_rd) ? slave_data(b_addr) : '0;

    fp_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_rd_data(a_m0_rd_data), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_rd_data(a_m1_rd_data), .m1_ack(a_m1_ack),
        .s_mmio_cs(a_cs), .s_mmio_wr(a_wr), .s_mmio_rd(a_rd), .s_mmio_addr(a_addr),
        .s_mmio_wr_data(a_wdata), .s_mmio_rd_data(a_rdata),
        .busy(a_busy), .grant_id(a_gid)
    );

    fp_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_fix (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_rd_data(b_m0_rd_data), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_rd_data(b_m1_rd_data), .m1_ack(b_m1_ack),
        .s_mmio_cs(b_cs), .s_mmio_wr(b_wr), .s_mmio_rd(b_rd), .s_mmio_addr(b_addr),
        .s_mmio_wr_data(b_wdata), .s_mmio_rd_data(b_rdata),
        .busy(b_busy), .grant_id(b_gid)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record bus transactions and acks of both instances; count unclean idle bus cycles.
    always @(negedge clk) begin : mon
        bus_ev_t be;
        ack_ev_t ae;
        if (a_cs) begin
            be = mk_bus(cyc, a_gid, a_wr, a_addr, a_wr ? a_wdata : a_rdata);
            be.rd = a_rd;
            a_bus_q.push_back(be);
        end else if (a_wr || a_rd || a_addr != '0 || a_wdata != '0) begin
            dirty_cnt++;
        end
        if (b_cs) begin
            be = mk_bus(cyc, b_gid, b_wr, b_addr, b_wr ? b_wdata : b_rdata);
            be.rd = b_rd;
            b_bus_q.push_back(be);
        end else if (b_wr || b_rd || b_addr != '0 || b_wdata != '0) begin
            dirty_cnt++;
        end
        if (a_m0_ack) begin ae = mk_ack(cyc, 1'b0, a_m0_rd_data); a_ack_q.push_back(ae); end
        if (a_m1_ack) begin ae = mk_ack(cyc, 1'b1, a_m1_rd_data); a_ack_q.push_back(ae); end
        if (b_m0_ack) begin ae = mk_ack(cyc, 1'b0, b_m0_rd_data); b_ack_q.push_back(ae); end
        if (b_m1_ack) begin ae = mk_ack(cyc, 1'b1, b_m1_rd_data); b_ack_q.push_back(ae); end
    end

    // Master model: raise req, keep it until n acks seen on the chosen instance, then drop.
    task automatic master_run(input logic id, input int n, input logic use_b, output int got);
        int c = 0;
        logic ack;
        got = 0;
        if (id) m1_req = 1'b1; else m0_req = 1'b1;
        while (got < n && c < 80) begin
            @(negedge clk);
            c++;
            ack = use_b ? (id ? b_m1_ack : b_m0_ack) : (id ? a_m1_ack : a_m0_ack);
            if (ack) got++;
        end
        @(posedge clk); #1;
        if (id) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
        a_bus_q.delete(); a_ack_q.delete(); b_bus_q.delete(); b_ack_q.delete();
        exp_bus_q.delete(); exp_ack_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_cs, a_wr, a_rd, a_m0_ack, a_m1_ack, a_busy, a_gid} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000000", {a_cs, a_wr, a_rd, a_m0_ack, a_m1_ack, a_busy, a_gid});
        end
        total++;
        if ({a_addr, a_wdata} !== '0) begin
            bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", a_addr, a_wdata);
        end
        total++;
        if ({a_m0_rd_data, a_m1_rd_data} !== '0) begin
            bad++; $display("FAIL reset_rd_data: got %h %h want 0", a_m0_rd_data, a_m1_rd_data);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_cs, a_busy, b_cs, b_busy} !== 4'b0) begin
            bad++; $display("FAIL reset_idle: got %b want 0000", {a_cs, a_busy, b_cs, b_busy});
        end
    endtask

    task automatic test_single_write();
        bus_ev_t e, o; ack_ev_t ea, oa; int unsigned t0; int got;
        settle();
        m0_wr = 1'b1; m0_addr = 21'h000040; m0_wr_data = 32'hA5A5_0001;
        t0 = cyc;
        exp_bus_q.push_back(mk_bus(t0 + 1, 1'b0, 1'b1, 21'h000040, 32'hA5A5_0001));
        exp_ack_q.push_back(mk_ack(t0 + 2, 1'b0, 32'h0));
        master_run(1'b0, 1, 1'b0, got);
        total++;
        if (got != 1) begin bad++; $display("FAIL wr_ack_count: got %0d want 1", got); end
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (a_bus_q.size() == 0) begin bad++; $display("FAIL wr_bus: got none want %h", e); end
            else begin o = a_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL wr_bus: got %h want %h", o, e); end end
        end
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); total++;
            if (a_ack_q.size() == 0) begin bad++; $display("FAIL wr_ack: got none want %h", ea); end
            else begin oa = a_ack_q.pop_front(); if (oa !== ea) begin bad++; $display("FAIL wr_ack: got %h want %h", oa, ea); end end
        end
        total++;
        if (a_bus_q.size() + a_ack_q.size() != 0) begin
            bad++; $display("FAIL wr_extra: got %0d extra events want 0", a_bus_q.size() + a_ack_q.size());
        end
    endtask

    task automatic test_single_read();
        bus_ev_t e, o; ack_ev_t ea, oa; int unsigned t0; int got;
        settle();
        m1_wr = 1'b0; m1_addr = 21'h000080; m1_wr_data = 32'h1234_5678;
        t0 = cyc;
        exp_bus_q.push_back(mk_bus(t0 + 1, 1'b1, 1'b0, 21'h000080, 32'h0000_BEEF));
        exp_ack_q.push_back(mk_ack(t0 + 2, 1'b1, 32'h0000_BEEF));
        master_run(1'b1, 1, 1'b0, got);
        total++;
        if (got != 1) begin bad++; $display("FAIL rd_ack_count: got %0d want 1", got); end
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (a_bus_q.size() == 0) begin bad++; $display("FAIL rd_bus: got none want %h", e); end
            else begin o = a_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rd_bus: got %h want %h", o, e); end end
        end
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); total++;
            if (a_ack_q.size() == 0) begin bad++; $display("FAIL rd_ack: got none want %h", ea); end
            else begin oa = a_ack_q.pop_front(); if (oa !== ea) begin bad++; $display("FAIL rd_ack: got %h want %h", oa, ea); end end
        end
        total++;
        if (a_m0_rd_data !== 32'h0) begin bad++; $display("FAIL rd_other_master: got %h want 0", a_m0_rd_data); end
    endtask

    task automatic test_round_robin();
        bus_ev_t e, o; ack_ev_t ea, oa; int unsigned t0; int g0, g1; logic id;
        settle();
        m0_wr = 1'b1; m0_addr = 21'h000100; m0_wr_data = 32'h1111_0000;
        m1_wr = 1'b0; m1_addr = 21'h000200; m1_wr_data = 32'h2222_0000;
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            id = 1'(k % 2);
            if (id) begin
                exp_bus_q.push_back(mk_bus(t0 + 1 + 3 * k, 1'b1, 1'b0, 21'h000200, slave_data(21'h000200)));
                exp_ack_q.push_back(mk_ack(t0 + 2 + 3 * k, 1'b1, slave_data(21'h000200)));
            end else begin
                exp_bus_q.push_back(mk_bus(t0 + 1 + 3 * k, 1'b0, 1'b1, 21'h000100, 32'h1111_0000));
                exp_ack_q.push_back(mk_ack(t0 + 2 + 3 * k, 1'b0, 32'h0));
            end
        end
        fork
            master_run(1'b0, 3, 1'b0, g0);
            master_run(1'b1, 3, 1'b0, g1);
        join
        total++;
        if (g0 != 3 || g1 != 3) begin bad++; $display("FAIL rr_ack_count: got %0d/%0d want 3/3", g0, g1); end
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (a_bus_q.size() == 0) begin bad++; $display("FAIL rr_bus: got none want %h", e); end
            else begin o = a_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rr_bus: got %h want %h", o, e); end end
        end
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); total++;
            if (a_ack_q.size() == 0) begin bad++; $display("FAIL rr_ack: got none want %h", ea); end
            else begin oa = a_ack_q.pop_front(); if (oa !== ea) begin bad++; $display("FAIL rr_ack: got %h want %h", oa, ea); end end
        end
    endtask

    task automatic test_fixed_priority();
        bus_ev_t e, o; ack_ev_t ea, oa; int unsigned t0; int g0, g1;
        settle();
        m0_wr = 1'b1; m0_addr = 21'h000104; m0_wr_data = 32'h3333_0000;
        m1_wr = 1'b0; m1_addr = 21'h000200;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_bus_q.push_back(mk_bus(t0 + 1 + 3 * k, 1'b0, 1'b1, 21'h000104, 32'h3333_0000));
            exp_ack_q.push_back(mk_ack(t0 + 2 + 3 * k, 1'b0, 32'h0));
        end
        exp_bus_q.push_back(mk_bus(t0 + 10, 1'b1, 1'b0, 21'h000200, slave_data(21'h000200)));
        exp_ack_q.push_back(mk_ack(t0 + 11, 1'b1, slave_data(21'h000200)));
        fork
            master_run(1'b0, 3, 1'b1, g0);
            master_run(1'b1, 1, 1'b1, g1);
        join
        total++;
        if (g0 != 3 || g1 != 1) begin bad++; $display("FAIL fix_ack_count: got %0d/%0d want 3/1", g0, g1); end
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (b_bus_q.size() == 0) begin bad++; $display("FAIL fix_bus: got none want %h", e); end
            else begin o = b_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL fix_bus: got %h want %h", o, e); end end
        end
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); total++;
            if (b_ack_q.size() == 0) begin bad++; $display("FAIL fix_ack: got none want %h", ea); end
            else begin oa = b_ack_q.pop_front(); if (oa !== ea) begin bad++; $display("FAIL fix_ack: got %h want %h", oa, ea); end end
        end
    endtask

    task automatic test_drop_during_issue();
        bus_ev_t e, o; ack_ev_t ea, oa; int unsigned t0;
        settle();
        m0_wr = 1'b0; m0_addr = 21'h000300; m0_wr_data = 32'h0;
        t0 = cyc;
        exp_bus_q.push_back(mk_bus(t0 + 1, 1'b0, 1'b0, 21'h000300, slave_data(21'h000300)));
        exp_ack_q.push_back(mk_ack(t0 + 2, 1'b0, slave_data(21'h000300)));
        m0_req = 1'b1;
        @(posedge clk); #1;
        m0_req = 1'b0; m0_wr = 1'b1; m0_addr = 21'h1FFFFF; m0_wr_data = 32'hDEAD_DEAD;
        repeat (5) @(posedge clk);
        #1;
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (a_bus_q.size() == 0) begin bad++; $display("FAIL drop_bus: got none want %h", e); end
            else begin o = a_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL drop_bus: got %h want %h", o, e); end end
        end
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front(); total++;
            if (a_ack_q.size() == 0) begin bad++; $display("FAIL drop_ack: got none want %h", ea); end
            else begin oa = a_ack_q.pop_front(); if (oa !== ea) begin bad++; $display("FAIL drop_ack: got %h want %h", oa, ea); end end
        end
        total++;
        if (a_bus_q.size() != 0 || a_busy !== 1'b0) begin
            bad++; $display("FAIL drop_idle: got extra=%0d busy=%b want 0 0", a_bus_q.size(), a_busy);
        end
        total++;
        if (a_m1_rd_data !== slave_data(21'h000200)) begin
            bad++; $display("FAIL drop_other_rd: got %h want %h", a_m1_rd_data, slave_data(21'h000200));
        end
    endtask

    task automatic test_reset_in_issue();
        bus_ev_t e, o; int unsigned t0; int g0, g1;
        settle();
        m1_wr = 1'b0; m1_addr = 21'h000080;
        m1_req = 1'b1;
        @(posedge clk); #1;
        total++;
        if (a_cs !== 1'b1) begin bad++; $display("FAIL rst_pre_cs: got %b want 1", a_cs); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({a_cs, a_rd, a_busy} !== 3'b000) begin
            bad++; $display("FAIL rst_async: got cs/rd/busy=%b want 000", {a_cs, a_rd, a_busy});
        end
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (a_ack_q.size() != 0 || a_bus_q.size() != 0 || a_m1_rd_data !== 32'h0) begin
            bad++; $display("FAIL rst_no_ack: got acks=%0d bus=%0d m1_rd=%h want 0 0 0", a_ack_q.size(), a_bus_q.size(), a_m1_rd_data);
        end
        @(posedge clk); #1;
        m0_wr = 1'b1; m0_addr = 21'h000010; m0_wr_data = 32'h0000_00AA;
        t0 = cyc;
        exp_bus_q.push_back(mk_bus(t0 + 1, 1'b0, 1'b1, 21'h000010, 32'h0000_00AA));
        exp_bus_q.push_back(mk_bus(t0 + 4, 1'b1, 1'b0, 21'h000080, 32'h0000_BEEF));
        fork
            master_run(1'b0, 1, 1'b0, g0);
            master_run(1'b1, 1, 1'b0, g1);
        join
        while (exp_bus_q.size() > 0) begin
            e = exp_bus_q.pop_front(); total++;
            if (a_bus_q.size() == 0) begin bad++; $display("FAIL rst_first_grant: got none want %h", e); end
            else begin o = a_bus_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rst_first_grant: got %h want %h", o, e); end end
        end
        repeat (4) @(posedge clk);
        total++;
        if (dirty_cnt != 0) begin bad++; $display("FAIL idle_bus_clean: got %0d dirty cycles want 0", dirty_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_drop_during_issue();
        test_reset_in_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_bus_arbiter.md
Name: fp_bus_arbiter

Overview:
- Shares the single FPro MMIO bus (mmio_cs/wr/rd/addr/data into the mmio subsystem) between two masters.
- m0 is the MicroBlaze bridge side. m1 is a hardware master, e.g. an autonomous LED/blink sequencer or a debug port.
- Each master sees a req/ack handshake. The arbiter grants one master, issues exactly one single-cycle FPro transaction, captures read data, and returns an ack.
- Sits between the bridge/second master and the mmio subsystem in the top level.

Parameters:
- ADDR_W, 21, FPro address width.
- DATA_W, 32, FPro data width.
- RR_EN, 1. 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 transaction request; held high until m0_ack
- m0_wr  in  1  1 = write, 0 = read; valid while m0_req
- m0_addr  in  ADDR_W  m0 target address
- m0_wr_data  in  DATA_W  m0 write data
- m0_rd_data  out  DATA_W  m0 read result; valid with m0_ack, held afterwards
- m0_ack  out  1  one-cycle completion pulse to m0
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_rd_data, m1_ack  same as m0, for m1
- s_mmio_cs  out  1  FPro chip select to mmio subsystem
- s_mmio_wr  out  1  FPro write strobe
- s_mmio_rd  out  1  FPro read strobe
- s_mmio_addr  out  ADDR_W  FPro address
- s_mmio_wr_data  out  DATA_W  FPro write data
- s_mmio_rd_data  in  DATA_W  FPro read data; combinational from slave in the cs/rd cycle
- busy  out  1  high in ISSUE and RESP
- grant_id  out  1  id of the last/current granted master

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All s_mmio_* = 0; m*_ack = 0; m*_rd_data = 0; busy = 0.
  - last_grant = 1, so m0 wins the first contention; grant_id = 0.
- FSM IDLE -> ISSUE -> RESP -> IDLE:
  - IDLE, neither req: stay; all strobes low.
  - IDLE, any req:
    - Pick winner. RR_EN=1: if both request, the master != last_grant wins; if only one requests, it wins. RR_EN=0: m0 wins whenever m0_req.
    - Latch winner id, wr, addr, wr_data into registers; go ISSUE.
  - ISSUE (exactly one cycle):
    - s_mmio_cs = 1; s_mmio_wr = lat_wr; s_mmio_rd = !lat_wr; addr/wr_data from latches.
    - On read, capture s_mmio_rd_data into the winner's rd_data register at the clock edge.
    - Go RESP.
  - RESP (one cycle): winner's ack = 1; last_grant = winner; go IDLE.
- Latency: req sampled high in IDLE at cycle t; FPro strobe at t+1; ack at t+2. A new grant is possible at t+3. Peak throughput is 1 transaction per 3 cycles.
- All s_mmio_* outputs and acks are registered; no combinational path from req to slave.
- s_mmio_addr/wr_data return to 0 outside ISSUE, so the bus is clean for probing.
- Write transactions leave the master's rd_data unchanged.
- Each rd_data register holds until that master's next read completes; the other master's register is never disturbed.
- Master must deassert req in the cycle after ack, or keep it high to request again. req high in IDLE after RESP is a new transaction.
- req dropped during ISSUE/RESP: the transaction still completes and ack still pulses; the arbiter does not abort.
- Request fields changing after grant are ignored; latched copies are used.
- Simultaneous req with RR_EN=1: grants alternate strictly (0,1,0,1...).
- A single continuously requesting master gets back-to-back grants every 3 cycles.
- reset_n asserted mid-ISSUE: strobes drop immediately (async); no ack is issued for that transaction.
- Address width: addresses pass through unmodified; no decoding is done here.

Decomposition:
- Package fp_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t.
  - typedef logic master_id_t.
  - localparams FP_ADDR_W = 21, FP_DATA_W = 32.
- Sub-module fp_rr_pick: combinational 2-way picker.
  - Inputs: req[1:0], last_grant, rr_en.
  - Outputs: gnt_valid, gnt_id.
  - Unit-testable on its own.

Test Plan:
- Single m0 write: addr 21'h000040, data 32'hA5A5_0001 → s_mmio_cs/wr high exactly at cycle t+1 with those values; m0_ack at t+2; m1_ack never high.
- Single m1 read: addr 21'h000080, slave returns 32'h0000_BEEF → s_mmio_rd at t+1; m1_rd_data = 32'h0000_BEEF with m1_ack at t+2; m0_rd_data still 0.
- Both masters hold req for 6 transactions, RR_EN=1 → grant order 0,1,0,1,0,1; acks spaced 3 cycles apart.
- Same contention with RR_EN=0 → m0 granted every time while it requests; m1 granted only after m0_req drops.
- m0 drops req during ISSUE → transaction still occurs and m0_ack still pulses; FSM returns to IDLE.
- reset_n pulsed low during ISSUE → s_mmio_cs falls asynchronously; no ack. After release with both requesting, the first grant goes to m0.
